// File: rtl/cpu_pkg.sv
// Shared CPU constants: next-PC select codes, vector addresses, IF/ID payload and ROM image.
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PCSRC_W  = 3;
  localparam int unsigned ROM_AW_DEF = 8;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0] IRQ_VEC_DEF  = 32'h8000_0004;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h8000_0008;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [PCSRC_W-1:0] {
    PCSRC_SEQ = 3'b000,
    PCSRC_BR  = 3'b001,
    PCSRC_J   = 3'b010,
    PCSRC_JR  = 3'b011,
    PCSRC_IRQ = 3'b100,
    PCSRC_EXC = 3'b101
  } pc_src_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            pc31;
    logic            valid;
  } if_id_t;

  // Program image: addiu-style encoding with the word index spread over the low fields
  function automatic logic [XLEN-1:0] rom_image(input logic [7:0] idx);
    return {6'b001001, 2'b00, idx, idx ^ 8'h5A, ~idx};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/decode controls in, PC and IF/ID register out.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               stall;
  logic               flush;
  logic [PCSRC_W-1:0] pc_src;
  logic               branch_taken;
  logic [XLEN-1:0]    branch_target;
  logic [XLEN-1:0]    jr_target;

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    if_id_instr;
  logic [XLEN-1:0]    if_id_pc_plus4;
  logic               if_id_pc31;
  logic               if_id_valid;

  modport master (
    output stall, flush, pc_src, branch_taken, branch_target, jr_target,
    input  pc, if_id_instr, if_id_pc_plus4, if_id_pc31, if_id_valid
  );

  modport slave (
    input  stall, flush, pc_src, branch_taken, branch_target, jr_target,
    output pc, if_id_instr, if_id_pc_plus4, if_id_pc31, if_id_valid
  );
endinterface

// File: rtl/fetch_stage_inst_rom.sv
// Combinational instruction ROM; the mode bit is ignored and addresses beyond the array read as nop.
module inst_rom
  import cpu_pkg::*;
#(
  parameter int unsigned ROM_AW = ROM_AW_DEF
) (
  input  logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] rdata
);

  logic [ROM_AW-1:0] word_idx;
  logic              in_range;
  logic [2:0]        unused_addr;

  assign word_idx    = addr[ROM_AW+1:2];
  assign in_range    = ~|addr[30:ROM_AW+2];
  assign unused_addr = {addr[31], addr[1:0]};

  always_comb begin
    rdata = NOP_INSTR;
    if (in_range) begin
      rdata = rom_image(8'(word_idx));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, instruction ROM and IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] IRQ_VEC  = IRQ_VEC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF,
  parameter int unsigned     ROM_AW   = ROM_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;

  logic [XLEN-1:0] fetch_word_c;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] target_c;
  logic            redirect_c;
  if_id_t          bubble_c;
  if_id_t          fetched_c;
  logic            unused_bt31;

  assign unused_bt31 = bus.branch_target[31];

  inst_rom #(
    .ROM_AW (ROM_AW)
  ) u_rom (
    .addr  (pc_q),
    .rdata (fetch_word_c)
  );

  // Carry out of bit 30 is dropped so sequential fetch never changes mode
  assign seq_pc_c = {pc_q[31], pc_q[30:0] + 31'd4};

  // Next-PC selection; unknown codes fall back to sequential
  always_comb begin
    redirect_c = 1'b0;
    target_c   = seq_pc_c;
    case (bus.pc_src)
      PCSRC_BR: begin
        if (bus.branch_taken) begin
          redirect_c = 1'b1;
          target_c   = {if_id_q.pc31, bus.branch_target[30:0]};
        end
      end
      PCSRC_J: begin
        redirect_c = 1'b1;
        target_c   = {if_id_q.pc_plus4[31:28], if_id_q.instr[25:0], 2'b00};
      end
      PCSRC_JR: begin
        // jr may drop to user mode but never raise to supervisor
        redirect_c = 1'b1;
        target_c   = {bus.jr_target[31] & if_id_q.pc31, bus.jr_target[30:0]};
      end
      PCSRC_IRQ: begin
        redirect_c = 1'b1;
        target_c   = IRQ_VEC;
      end
      PCSRC_EXC: begin
        redirect_c = 1'b1;
        target_c   = EXC_VEC;
      end
      default: begin
        redirect_c = 1'b0;
        target_c   = seq_pc_c;
      end
    endcase
  end

  // PC and IF/ID update: stall freezes PC, squash/flush turns the fetched word into a bubble
  always_comb begin
    pc_d      = pc_q;
    if_id_d   = if_id_q;
    bubble_c  = '{instr: NOP_INSTR, pc_plus4: seq_pc_c, pc31: pc_q[31], valid: 1'b0};
    fetched_c = '{instr: fetch_word_c, pc_plus4: seq_pc_c, pc31: pc_q[31], valid: 1'b1};
    if (!bus.stall) begin
      pc_d    = target_c;
      if_id_d = (bus.flush || redirect_c) ? bubble_c : fetched_c;
    end else if (bus.flush) begin
      if_id_d = bubble_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = if_id_q.instr;
  assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
  assign bus.if_id_pc31     = if_id_q.pc31;
  assign bus.if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_fetch_stage;

  logic clk;
  logic reset;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_pc31, m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rom_m(input logic [31:0] a);
    logic [31:0] idx;
    if ((a & 32'h7FFF_FC00) != 0) return 32'h0;
    idx = (a >> 2) & 32'hFF;
    return 32'h2400_0000 | (idx << 16) | ((idx ^ 32'h5A) << 8) | ((~idx) & 32'hFF);
  endfunction

  // Advance the model by one clock from the current inputs
  task automatic model_step();
    logic [31:0] seqv, word, tgt;
    logic        redir;
    if (reset) begin
      m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_pc31 = 0; m_valid = 0;
      return;
    end
    seqv  = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    word  = rom_m(m_pc);
    redir = 1'b1;
    tgt   = seqv;
    case (bus.pc_src)
      3'd1: if (bus.branch_taken) tgt = {m_pc31, 31'b0} | (bus.branch_target & 32'h7FFF_FFFF);
            else redir = 1'b0;
      3'd2: tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      3'd3: tgt = bus.jr_target & {m_pc31, 31'h7FFF_FFFF};
      3'd4: tgt = 32'h8000_0004;
      3'd5: tgt = 32'h8000_0008;
      default: redir = 1'b0;
    endcase
    if (bus.stall) begin
      if (bus.flush) begin
        m_instr = 0; m_valid = 0; m_pc4 = seqv; m_pc31 = m_pc[31];
      end
    end else begin
      if (bus.flush || redir) begin
        m_instr = 0; m_valid = 0;
      end else begin
        m_instr = word; m_valid = 1;
      end
      m_pc4  = seqv;
      m_pc31 = m_pc[31];
      m_pc   = tgt;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    check_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("pc",       bus.pc,                     m_pc);
      chk("instr",    bus.if_id_instr,            m_instr);
      chk("pc_plus4", bus.if_id_pc_plus4,         m_pc4);
      chk("pc31",     32'(bus.if_id_pc31),        32'(m_pc31));
      chk("valid",    32'(bus.if_id_valid),       32'(m_valid));
    end
  end

  task automatic cyc(input logic [2:0] src, input logic bt, input logic [31:0] btgt,
                     input logic [31:0] jt, input logic st, input logic fl);
    reset             = 1'b0;
    bus.pc_src        = src;
    bus.branch_taken  = bt;
    bus.branch_target = btgt;
    bus.jr_target     = jt;
    bus.stall         = st;
    bus.flush         = fl;
    @(negedge clk);
  endtask

  task automatic seq1();
    cyc(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.pc_src = 3'd0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.jr_target = 32'h0; bus.stall = 1'b0; bus.flush = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc",    bus.pc, 32'h8000_0000);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_instr", bus.if_id_instr, 32'h0);
    chk("rst_pc4",   bus.if_id_pc_plus4, 32'h0);
    chk("rst_pc31",  32'(bus.if_id_pc31), 32'h0);

    seq1();
    chk("seq1_pc", bus.pc, 32'h8000_0004);
    chk("seq1_valid", 32'(bus.if_id_valid), 32'h1);
    chk("seq1_pc31", 32'(bus.if_id_pc31), 32'h1);
    chk("seq1_instr", bus.if_id_instr, 32'h2400_5AFF);
    seq1();
    chk("seq2_pc", bus.pc, 32'h8000_0008);

    cyc(3'd3, 1'b0, 32'h0, 32'h0000_000C, 1'b0, 1'b0);
    chk("jr_low_pc", bus.pc, 32'h0000_000C);
    chk("jr_low_valid", 32'(bus.if_id_valid), 32'h0);
    seq1();
    chk("seq_low_pc", bus.pc, 32'h0000_0010);
    cyc(3'd1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0);
    chk("br_nt_pc", bus.pc, 32'h0000_0014);
    chk("br_nt_valid", 32'(bus.if_id_valid), 32'h1);
    cyc(3'd1, 1'b1, 32'h0000_0040, 32'h0, 1'b0, 1'b0);
    chk("br_t_pc", bus.pc, 32'h0000_0040);
    chk("br_t_valid", 32'(bus.if_id_valid), 32'h0);

    cyc(3'd3, 1'b0, 32'h0, 32'h8000_1000, 1'b0, 1'b0);
    chk("jr_user_pc", bus.pc, 32'h0000_1000);
    cyc(3'd4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("irq_pc", bus.pc, 32'h8000_0004);
    seq1();
    cyc(3'd3, 1'b0, 32'h0, 32'h8000_1000, 1'b0, 1'b0);
    chk("jr_sup_pc", bus.pc, 32'h8000_1000);

    cyc(3'd4, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stall_irq_pc", bus.pc, 32'h8000_1000);
    cyc(3'd4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("irq2_pc", bus.pc, 32'h8000_0004);
    chk("irq2_valid", 32'(bus.if_id_valid), 32'h0);

    seq1();
    cyc(3'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("sf_pc", bus.pc, 32'h8000_0008);
    chk("sf_valid", 32'(bus.if_id_valid), 32'h0);
    chk("sf_instr", bus.if_id_instr, 32'h0);
    seq1();
    chk("resume_pc", bus.pc, 32'h8000_000C);
    chk("resume_instr", bus.if_id_instr, 32'h2402_58FD);

    cyc(3'd3, 1'b0, 32'h0, 32'h0000_0400, 1'b0, 1'b0);
    seq1();
    chk("oor_instr", bus.if_id_instr, 32'h0);
    chk("oor_valid", 32'(bus.if_id_valid), 32'h1);

    cyc(3'd3, 1'b0, 32'h0, 32'h7FFF_FFFC, 1'b0, 1'b0);
    seq1();
    chk("wrap_user", bus.pc, 32'h0000_0000);
    cyc(3'd5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("exc_pc", bus.pc, 32'h8000_0008);
    seq1();
    cyc(3'd3, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    seq1();
    chk("wrap_sup", bus.pc, 32'h8000_0000);

    seq1(); seq1();
    cyc(3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("j_pc", bus.pc, 32'h8005_6FF8);

    cyc(3'd7, 1'b1, 32'h0000_0080, 32'h0, 1'b0, 1'b0);
    chk("code7_pc", bus.pc, 32'h8005_6FFC);

    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pc", bus.pc, 32'h8000_0000);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tb_t, tj_t;
      tb_t = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                         : (($urandom_range(0, 1) << 31) | ($urandom_range(0, 300) << 2));
      tj_t = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                         : (($urandom_range(0, 1) << 31) | ($urandom_range(0, 300) << 2));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        @(negedge clk);
      end else begin
        cyc(($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
            1'($urandom_range(0, 1)), tb_t, tj_t,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
